// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg
//   Shared definitions for the memory-mapped UART transmitter:
//   - register word offsets (selected by mem_addr[3:2])
//   - STATUS bit indices
//   - TX FSM state encodings
//   - small helpers for parity and the effective bit period
//   Optional feature macro: MMIO_UART_PARITY_EN (adds the PARITY state).
package mmio_uart_pkg;

    // Register offsets as word indices within the 16-byte window
    localparam logic [1:0] UART_OFF_DATA   = 2'd0;
    localparam logic [1:0] UART_OFF_STATUS = 2'd1;
    localparam logic [1:0] UART_OFF_DIV    = 2'd2;
    localparam logic [1:0] UART_OFF_LEVEL  = 2'd3;

    // STATUS bit indices
    localparam int unsigned ST_BUSY  = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_EMPTY = 2;
    localparam int unsigned ST_OVR   = 3;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef MMIO_UART_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4
    } tx_state_e;

    // Even parity bit: makes the total count of ones (data + parity) even
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    // DIV=0 is treated as one clock per bit
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/mmio_uart_fifo.sv
// mmio_uart_fifo
//   Small synchronous FIFO for the UART TX path. Pointers carry an extra
//   wrap bit; full/empty/level are derived from the pointer pair only.
//   A push while full is ignored (the caller records the overrun), even if
//   a pop happens on the same edge.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (pointers only)
//   push, wdata     write request and byte
//   pop             read request (ignored when empty)
//   rdata           head-of-queue data (combinational)
//   full, empty     occupancy flags
//   level           number of stored entries
module mmio_uart_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign level     = r_wptr - r_rptr;
    assign rdata     = r_mem[r_rptr[AW-1:0]];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped UART transmitter (8N1, or 8E1 when MMIO_UART_PARITY_EN is
//   defined). Software pushes bytes into a TX FIFO through DATA; a baud FSM
//   serialises them LSB first onto tx. Reads are combinational and never
//   change state, since instruction fetch drives the same address bus.
// Registers (offset mem_addr[3:2]):
//   0x0 DATA   W    lane 0 pushes mem_wdata[7:0]; full -> dropped, OVR set
//   0x4 STATUS R/W1C {OVR, EMPTY, FULL, BUSY}; lane 0 bit3=1 clears OVR
//   0x8 DIV    R/W  clocks per bit, lanes 0/1; 0 behaves as 1
//   0xC LEVEL  R    FIFO count
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   mem_addr        CPU bus address
//   mem_wdata       CPU store data
//   mem_wenable     byte-lane write strobes (one-cycle pulse per store)
//   mem_rdata       combinational read data, 0 outside the window
//   hit             address falls in the 16-byte window
//   tx              registered serial output, idle high
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wenable,
    output logic [31:0] mem_rdata,
    output logic        hit,
    output logic        tx
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    w_reg_sel;
    logic          w_data_wr;
    logic          w_ovr_clr;
    logic          w_div_wr;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;
    logic [7:0]    w_fifo_rdata;
    logic [15:0]   w_div_eff;
    logic          w_bit_end;
    logic          w_busy;
    logic          w_unused;

    tx_state_e     r_state;
    logic          r_tx;
    logic [7:0]    r_shift;
    logic [15:0]   r_bit_cnt;
    logic [2:0]    r_idx;
    logic          r_ovr;
    logic [15:0]   r_div;
`ifdef MMIO_UART_PARITY_EN
    logic          r_parity;
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign hit       = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign w_reg_sel = mem_addr[3:2];
    assign w_data_wr = hit && (w_reg_sel == UART_OFF_DATA) && mem_wenable[0];
    assign w_ovr_clr = hit && (w_reg_sel == UART_OFF_STATUS) && mem_wenable[0] && mem_wdata[3];
    assign w_div_wr  = hit && (w_reg_sel == UART_OFF_DIV);

    assign w_unused  = ^{mem_addr[1:0], mem_wdata[31:16], mem_wenable[3:2]};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    mmio_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_data_wr),
        .wdata (mem_wdata[7:0]),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    // ------------------------------------------------------------------
    // OVR: sticky, set by a store into a full FIFO; set beats clear
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if (w_data_wr && w_full) begin
            r_ovr <= 1'b1;
        end else if (w_ovr_clr) begin
            r_ovr <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // DIV register, bytewise on lanes 0 and 1
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= DEFAULT_DIV;
        end else if (w_div_wr) begin
            if (mem_wenable[0]) begin
                r_div[7:0] <= mem_wdata[7:0];
            end
            if (mem_wenable[1]) begin
                r_div[15:8] <= mem_wdata[15:8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational, side-effect free)
    // ------------------------------------------------------------------
    assign w_busy = (r_state != StIdle);

    always_comb begin
        mem_rdata = 32'd0;
        if (hit) begin
            case (w_reg_sel)
                UART_OFF_STATUS: begin
                    mem_rdata[ST_BUSY]  = w_busy;
                    mem_rdata[ST_FULL]  = w_full;
                    mem_rdata[ST_EMPTY] = w_empty;
                    mem_rdata[ST_OVR]   = r_ovr;
                end
                UART_OFF_DIV:   mem_rdata[15:0]   = r_div;
                UART_OFF_LEVEL: mem_rdata[LW-1:0] = w_level;
                default:        mem_rdata         = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    // The bit counter is loaded with the current DIV at every bit boundary,
    // so a DIV write only affects bits that start after it.
    assign w_div_eff = eff_div(r_div);
    assign w_bit_end = (r_bit_cnt == 16'd1);
    assign w_pop     = (r_state == StIdle) && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_tx      <= 1'b1;
            r_shift   <= 8'd0;
            r_bit_cnt <= 16'd1;
            r_idx     <= 3'd0;
`ifdef MMIO_UART_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift   <= w_fifo_rdata;
                        r_bit_cnt <= w_div_eff;
                        r_state   <= StStart;
                        r_tx      <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
                        r_parity  <= even_parity(w_fifo_rdata);
`endif
                    end
                end
                StStart: begin
                    if (w_bit_end) begin
                        r_state <= StData;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_idx   <= 3'd0;
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        if (r_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                            r_state <= StParity;
                            r_tx    <= r_parity;
`else
                            r_state <= StStop;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end
                end
`ifdef MMIO_UART_PARITY_EN
                StParity: begin
                    if (w_bit_end) begin
                        r_state <= StStop;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (w_bit_end) begin
                        r_state <= StIdle;
                        r_tx    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_tx    <= 1'b1;
                end
            endcase

            if (r_state != StIdle) begin
                r_bit_cnt <= w_bit_end ? w_div_eff : (r_bit_cnt - 16'd1);
            end
        end
    end

    assign tx = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
//   Scoreboarded bench for mmio_uart_tx: stores push expected bytes into a
//   queue, a serial-line monitor decodes frames and compares against it.
//   Directed sections check register values, bit timing and reset.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef MMIO_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wenable;
    logic [31:0] mem_rdata;
    logic        hit;
    logic        tx;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    bit          mon_en   = 1'b1;
    int          mon_div  = 16;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (4),
        .DEFAULT_DIV (16'd16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wenable (mem_wenable),
        .mem_rdata   (mem_rdata),
        .hit         (hit),
        .tx          (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Drive a store; commits at the next posedge, returns 1 time unit after it
    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
        mem_addr    = addr;
        mem_wdata   = data;
        mem_wenable = strb;
        @(posedge clk);
        #1;
        mem_wenable = 4'd0;
    endtask

    // Combinational read, sampled on the falling edge
    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        mem_addr    = addr;
        mem_wenable = 4'd0;
        @(negedge clk);
        data = mem_rdata;
    endtask

    task automatic store(input logic [7:0] b, input bit expect_tx);
        if (expect_tx) exp_q.push_back(b);
        bus_wr(BASE, {24'd0, b}, 4'b0001);
    endtask

    // Wait until every expected frame was seen and the FSM is idle
    task automatic drain(input int max_cycles);
        logic [31:0] st;
        bit          done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            bus_rd(BASE + 32'h4, st);
            if (exp_q.size() == 0 && st[0] == 1'b0) done = 1'b1;
        end
        chk("drain", {31'd0, done}, 32'd1);
    endtask

    // Serial monitor: samples each bit mid-period using mon_div
    initial begin : monitor
        int         p;
        logic [7:0] b;
        logic [7:0] e;
        logic       par;
        logic       stp;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx === 1'b0) begin
                p = mon_div;
                b = 8'd0;
                repeat (p / 2) @(negedge clk);
                chk("mon_start", {31'd0, tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (p) @(negedge clk);
                    b[i] = tx;
                end
                par = 1'b0;
`ifdef MMIO_UART_PARITY_EN
                repeat (p) @(negedge clk);
                par = tx;
`endif
                repeat (p) @(negedge clk);
                stp = tx;
                chk("mon_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("mon_byte", {24'd0, b}, {24'd0, e});
`ifdef MMIO_UART_PARITY_EN
                    chk("mon_parity", {31'd0, par}, {31'd0, ^e});
`endif
                end
                chk("mon_stop", {31'd0, stp}, 32'd1);
            end
        end
    end

    initial begin : stim
        logic [31:0] rd;
        logic [7:0]  pat;
        logic [3:0]  seg;
        logic        lvl;
        logic [23:0] cap;
        logic [31:0] a;
        bit          saw_low;

        rst_n       = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;
        mem_wenable = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- reset values and decode ----
        bus_rd(BASE + 32'h4, rd);  chk("rst_status", rd, 32'h4);
        bus_rd(BASE + 32'h8, rd);  chk("rst_div", rd, 32'd16);
        bus_rd(BASE + 32'hC, rd);  chk("rst_level", rd, 32'd0);
        chk("hit_in", {31'd0, hit}, 32'd1);
        bus_rd(BASE + 32'h0, rd);  chk("data_rd0", rd, 32'd0);
        bus_rd(BASE + 32'h14, rd); chk("miss_rd", rd, 32'd0);
        chk("hit_out", {31'd0, hit}, 32'd0);
        bus_rd(BASE - 32'h4, rd);  chk("hit_below", {31'd0, hit}, 32'd0);

        // ---- DIV bytewise lanes ----
        bus_wr(BASE + 32'h8, 32'hABCD_1234, 4'b0001);
        bus_rd(BASE + 32'h8, rd);  chk("div_lane0", rd, 32'h0000_0034);
        bus_wr(BASE + 32'h8, 32'hABCD_12FF, 4'b0010);
        bus_rd(BASE + 32'h8, rd);  chk("div_lane1", rd, 32'h0000_1234);

        // ---- single frame 0x55 at DIV=4 with exact bit timing ----
        bus_wr(BASE + 32'h8, 32'd4, 4'b0011);
        mon_div = 4;
        pat = 8'h55;
        store(pat, 1'b1);
        bus_rd(BASE + 32'h4, rd);  chk("empty_cleared", rd, 32'h0);
        mem_addr = BASE + 32'h4;
        for (int j = 0; j < NB; j++) begin
            if (j == 0) lvl = 1'b0;
            else if (j <= 8) lvl = pat[j-1];
            else if (j == NB - 1) lvl = 1'b1;
            else lvl = ^pat;
            for (int s = 0; s < 4; s++) begin
                @(posedge clk);
                #1;
                seg[s] = tx;
                if (j == NB - 1 && s == 3) chk("busy_last", {31'd0, mem_rdata[0]}, 32'd1);
            end
            chk($sformatf("seg%0d", j), {28'd0, seg}, {28'd0, {4{lvl}}});
        end
        @(posedge clk);
        #1;
        chk("busy_done", {31'd0, mem_rdata[0]}, 32'd0);
        drain(200);

        // ---- overrun with 5+1 back-to-back stores at DIV=16 ----
        bus_wr(BASE + 32'h8, 32'd16, 4'b0011);
        mon_div = 16;
        store(8'h11, 1'b1);
        store(8'h22, 1'b1);
        store(8'h33, 1'b1);
        store(8'h44, 1'b1);
        store(8'h5A, 1'b1);
        bus_rd(BASE + 32'hC, rd);  chk("level_full", rd, 32'd4);
        bus_rd(BASE + 32'h4, rd);  chk("status_full", rd, 32'h3);
        store(8'h66, 1'b0);
        bus_rd(BASE + 32'h4, rd);  chk("ovr_set", rd, 32'hB);
        bus_rd(BASE + 32'hC, rd);  chk("level_after_drop", rd, 32'd4);
        bus_wr(BASE + 32'h4, 32'h0, 4'b0001);
        bus_rd(BASE + 32'h4, rd);  chk("ovr_no_clr", rd, 32'hB);
        bus_wr(BASE + 32'h4, 32'h8, 4'b0001);
        bus_rd(BASE + 32'h4, rd);  chk("ovr_clr", rd, 32'h3);

        // ---- fetch-like read sweep while busy ----
        for (int i = 0; i < 24; i++) begin
            a = (i % 3 == 0) ? (i * 4) : (BASE + ((i % 4) * 4));
            bus_rd(a, rd);
            if (a[31:4] != BASE[31:4]) begin
                chk("sweep_miss", {31'd0, hit}, 32'd0);
                chk("sweep_miss_rd", rd, 32'd0);
            end else begin
                case (a[3:2])
                    2'd0:    chk("sweep_data", rd, 32'd0);
                    2'd1:    chk("sweep_status", rd, 32'h3);
                    2'd2:    chk("sweep_div", rd, 32'd16);
                    default: chk("sweep_level", rd, 32'd4);
                endcase
            end
        end
        bus_rd(BASE + 32'hC, rd);  chk("level_after_sweep", rd, 32'd4);
        drain(1500);

        // ---- DIV change mid-DATA: bit0 keeps 4 clocks, later bits 8 ----
        bus_wr(BASE + 32'h8, 32'd4, 4'b0011);
        mon_en = 1'b0;
        bus_wr(BASE, 32'h55, 4'b0001);
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            cap[k] = tx;
            if (k == 5) begin
                mem_addr    = BASE + 32'h8;
                mem_wdata   = 32'd8;
                mem_wenable = 4'b0011;
            end
            if (k == 6) mem_wenable = 4'd0;
        end
        chk("div_change", {8'd0, cap}, 32'h00FF_00F0);
        drain(200);
        bus_rd(BASE + 32'h8, rd);  chk("div_now8", rd, 32'd8);
        mon_en = 1'b1;

        // ---- DIV=0 behaves as 1, back-to-back frames ----
        bus_wr(BASE + 32'h8, 32'd0, 4'b0011);
        bus_rd(BASE + 32'h8, rd);  chk("div_zero", rd, 32'd0);
        mon_div = 1;
        store(8'h3C, 1'b1);
        store(8'hC3, 1'b1);
        store(8'h07, 1'b1);
        drain(200);

        // ---- writes that must not push: miss and wrong lane ----
        bus_wr(BASE + 32'h10, 32'hAA, 4'b0001);
        bus_wr(BASE, 32'hBB00, 4'b0010);
        bus_rd(BASE + 32'hC, rd);  chk("no_push", rd, 32'd0);
        bus_rd(BASE + 32'h4, rd);  chk("no_push_status", rd, 32'h4);

        // ---- reset mid-frame ----
        mon_en = 1'b0;
        bus_wr(BASE + 32'h8, 32'd4, 4'b0011);
        bus_wr(BASE, 32'hF0, 4'b0001);
        bus_wr(BASE, 32'h0F, 4'b0001);
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", {31'd0, tx}, 32'd1);
        bus_rd(BASE + 32'hC, rd);  chk("rst_mid_level", rd, 32'd0);
        bus_rd(BASE + 32'h4, rd);  chk("rst_mid_status", rd, 32'h4);
        #2;
        rst_n = 1'b1;
        bus_rd(BASE + 32'h8, rd);  chk("rst_mid_div", rd, 32'd16);
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        chk("rst_no_frame", {31'd0, saw_low}, 32'd0);
        bus_rd(BASE + 32'h4, rd);  chk("rst_idle_status", rd, 32'h4);
        mon_en = 1'b1;

        // ---- 0x07 after reset (parity bit 1 when compiled in) ----
        mon_div = 16;
        store(8'h07, 1'b1);
        drain(400);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
